ahb_debug_regfile: RTL and testbench
====================================

Name: ahb_debug_regfile

Overview:
- Parametrised AHB-Lite slave holding the cocotb debug registers at the top of the user-project window.
- Generalises the fixed two-register debug bank to NUM_REGS registers with byte-lane writes, an error response and a doorbell interrupt.
- Sits inside user_project_wrapper in parallel with user logic.
- Exports `dbg_sel` so the wrapper can mux HRDATA, HREADYOUT and HRESP between this block and the user slave.

Parameters:
- NUM_REGS, 2, number of 32-bit debug registers; power of two, 2..16.
- WIN_BITS, 24, width of the decoded window offset; the registers occupy the last NUM_REGS words of the 2^WIN_BITS-byte window.
- RESET_VAL, 32'h0, reset value of every register.

Ports:
- HCLK  in  1  bus clock; all state on the rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from the wrapper decoder.
- HADDR  in  32  address.
- HTRANS  in  2  transfer type; only NONSEQ (2'b10) and SEQ (2'b11) are active.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus ready; qualifies the address phase.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- dbg_sel  out  1  registered: the current data phase targets this block.
- irq  out  1  doorbell interrupt, level.

Behaviour:
- Let IW = log2(NUM_REGS).
- hit = HSEL & HREADY & HTRANS[1] & (HADDR[WIN_BITS-1:IW+2] all ones).
- Register index = HADDR[IW+1:2].
  - NUM_REGS=2 gives offsets 0xFFFFF8 (index 0) and 0xFFFFFC (index 1).
- Address phase, on hit: latch index, HWRITE, HSIZE and HADDR[1:0] into data-phase registers; set dbg_sel=1.
- Address phase, no hit: dbg_sel=0 at the next edge, except that dbg_sel holds 1 while this block is stalling.
- Data-phase FSM states: IDLE, DATA, ERR1, ERR2.
- IDLE -> DATA on a hit with a legal size.
- IDLE -> ERR1 on a hit with an illegal size:
  - HSIZE > 3'b010, or
  - a misaligned halfword (HADDR[0]=1), or
  - a misaligned word (HADDR[1:0]!=0).
- ERR1: HREADYOUT=0, HRESP=1; next state ERR2.
- ERR2: HREADYOUT=1, HRESP=1; then IDLE, or DATA/ERR1 if a new hit is accepted this cycle.
- An errored access never updates a register.
- DATA: HREADYOUT=1, HRESP=0.
  - Write: update only the enabled byte lanes at the closing edge.
    - Byte: lane HADDR[1:0].
    - Halfword: lanes {HADDR[1],0} and {HADDR[1],1}.
    - Word: all four lanes.
  - Read: HRDATA = register[latched index], combinational from the register array.
- Pipelined back-to-back transfers are supported. A read of a register immediately after a write to it returns the new value, because the write commits before the read's data phase.
- HRDATA = 0 whenever the block is not in a read data phase.
- Doorbell is register NUM_REGS-1:
  - A completed write leaving it non-zero sets irq at the same edge.
  - A completed write leaving it zero clears irq.
  - irq is a registered output.
- Reset (asynchronous, any time, including mid-transfer):
  - registers = RESET_VAL;
  - FSM = IDLE;
  - HREADYOUT=1, HRESP=0, HRDATA=0, dbg_sel=0, irq=0.
- On reset deassertion, the first accepted address phase is the one sampled on the first rising edge after release.
- Unselected or IDLE/BUSY HTRANS: no state change, OKAY response.

Optional Feature:
- Macro: DBG_WAIT_STATE_EN.
- Defined:
  - Every legal read inserts exactly one wait state: DATA is preceded by a WAIT state with HREADYOUT=0 and HRESP=0.
  - HRDATA is valid in the following cycle, with HREADYOUT=1.
  - Writes and errors are unchanged.
  - The bench uses this to exercise master stall handling.
- Undefined: zero-wait reads as described in Behaviour; the WAIT state is not present.

Test Plan:
- Reset: hold HRESETn=0 -> HRDATA=0, HREADYOUT=1, HRESP=0, irq=0, dbg_sel=0; then read 0x30FFFFF8 -> 32'h0.
- Word write then read, NUM_REGS=2:
  - write 0x30FFFFF8 <= 32'hDEADBEEF, then read it back -> 32'hDEADBEEF with OKAY;
  - read 0x30FFFFFC -> 0.
- Byte lanes:
  - word-write 32'h11223344, then byte-write 0xAA at offset +2 -> read 32'h11AA3344;
  - halfword-write 0x5566 at offset +0 -> read 32'h11AA5566.
- Error: word write to 0x30FFFFF9, or HSIZE=3'b011 ->
  - HREADYOUT 0 then 1 with HRESP=1 in both cycles;
  - the register is unchanged on readback.
- Doorbell, NUM_REGS=4:
  - write 0x30FFFFFC <= 1 -> irq=1 at the next edge;
  - write 0 -> irq=0;
  - write to 0x30FFFFF0 -> irq unaffected.
- Mid-transfer reset:
  - assert HRESETn low during ERR1 -> HREADYOUT=1 and HRESP=0 immediately, without waiting for a clock edge;
  - all registers read RESET_VAL after release.
- Wait state: with DBG_WAIT_STATE_EN defined, a read gives exactly one HREADYOUT=0 cycle, then the correct data.

Source files
------------

// File: rtl/ahb_debug_regfile.sv
// AHB-Lite debug register bank: NUM_REGS byte-writable registers at the top of the window,
// ERROR response for illegal sizes, doorbell irq on the last register. Optional macro: DBG_WAIT_STATE_EN.
module ahb_debug_regfile #(
    parameter int          NUM_REGS  = 2,
    parameter int          WIN_BITS  = 24,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        dbg_sel,
    output logic        irq
);
    localparam int IW = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DATA = 3'd1,
        S_ERR1 = 3'd2,
        S_ERR2 = 3'd3
`ifdef DBG_WAIT_STATE_EN
        , S_WAIT = 3'd4
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          wr_q, wr_d;
    logic [2:0]    size_q, size_d;
    logic [1:0]    lo_q, lo_d;
    logic          dbg_sel_q, dbg_sel_d;
    logic          irq_q, irq_d;
    logic [31:0]   regs_q [NUM_REGS];
    logic [31:0]   regs_d [NUM_REGS];

    logic          hit, legal, accept, commit;
    logic [3:0]    be;
    logic          unused_bits;

    assign unused_bits = ^{HADDR[31:WIN_BITS], HTRANS[0]};

    assign hit    = HSEL & HREADY & HTRANS[1] & (&HADDR[WIN_BITS-1:IW+2]);
    assign legal  = (HSIZE == 3'b000) |
                    ((HSIZE == 3'b001) & ~HADDR[0]) |
                    ((HSIZE == 3'b010) & (HADDR[1:0] == 2'b00));
    // A new address phase can only be taken while the previous data phase is completing.
    assign accept = hit & ((state_q == S_IDLE) | (state_q == S_DATA) | (state_q == S_ERR2));
    assign commit = (state_q == S_DATA) & wr_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        size_d    = size_q;
        lo_d      = lo_q;
        case (state_q)
            S_ERR1: state_d = S_ERR2;
`ifdef DBG_WAIT_STATE_EN
            S_WAIT: state_d = S_DATA;
`endif
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    idx_d  = HADDR[IW+1:2];
                    wr_d   = HWRITE;
                    size_d = HSIZE;
                    lo_d   = HADDR[1:0];
                    if (!legal) begin
                        state_d = S_ERR1;
                    end else begin
                        state_d = S_DATA;
`ifdef DBG_WAIT_STATE_EN
                        if (!HWRITE) state_d = S_WAIT;
`endif
                    end
                end
            end
        endcase
        dbg_sel_d = (state_d != S_IDLE);
    end

    always_comb begin
        be = 4'b1111;
        case (size_q)
            3'b000:  be = 4'b0001 << lo_q;
            3'b001:  be = lo_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (commit && (idx_q == IW'(i))) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) regs_d[i][8*b +: 8] = HWDATA[8*b +: 8];
                end
            end
        end
        irq_d = irq_q;
        // Doorbell level follows the last register's contents after any write to it.
        if (commit && (idx_q == IW'(NUM_REGS - 1))) irq_d = |regs_d[NUM_REGS-1];
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            size_q    <= 3'b000;
            lo_q      <= 2'b00;
            dbg_sel_q <= 1'b0;
            irq_q     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            lo_q      <= lo_d;
            dbg_sel_q <= dbg_sel_d;
            irq_q     <= irq_d;
            regs_q    <= regs_d;
        end
    end

`ifdef DBG_WAIT_STATE_EN
    assign HREADYOUT = ~((state_q == S_ERR1) | (state_q == S_WAIT));
`else
    assign HREADYOUT = (state_q != S_ERR1);
`endif
    assign HRESP   = (state_q == S_ERR1) | (state_q == S_ERR2);
    assign HRDATA  = ((state_q == S_DATA) && !wr_q) ? regs_q[idx_q] : 32'h0;
    assign dbg_sel = dbg_sel_q;
    assign irq     = irq_q;
endmodule

// File: tb/tb_ahb_debug_regfile.sv
// Randomised and directed bench for ahb_debug_regfile (NUM_REGS=4) against a byte-level model.
module tb_ahb_debug_regfile;
    localparam int NR = 4;
`ifdef DBG_WAIT_STATE_EN
    localparam int WS = 1;
`else
    localparam int WS = 0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b000;
    logic [31:0] HWDATA = '0;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT, HRESP, dbg_sel, irq;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] model [NR];
    logic        irq_m;

    always #5 HCLK = ~HCLK;

    // Wrapper-style ready mux: the other slave is always ready.
    assign HREADY = dbg_sel ? HREADYOUT : 1'b1;

    ahb_debug_regfile #(.NUM_REGS(NR), .WIN_BITS(24), .RESET_VAL(32'h0)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .dbg_sel(dbg_sel), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model[i] = 32'h0;
        irq_m = 1'b0;
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return ({8'h0, a[23:0]} >= (32'h0100_0000 - 4 * NR));
    endfunction

    function automatic int reg_idx(input logic [31:0] a);
        return int'(({8'h0, a[23:0]} - (32'h0100_0000 - 4 * NR)) / 4);
    endfunction

    function automatic bit bad_size(input logic [31:0] a, input logic [2:0] sz);
        if (sz > 3'd2) return 1'b1;
        return ((a % (32'd1 << sz)) != 0);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int idx, first, nb;
        idx   = reg_idx(a);
        nb    = 1 << sz;
        first = int'(a % 4);
        for (int b = 0; b < 4; b++)
            if (b >= first && b < first + nb) model[idx][8*b +: 8] = wd[8*b +: 8];
        if (idx == NR - 1) irq_m = (model[idx] != 0);
    endtask

    task automatic xfer(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [1:0] tr, output logic [31:0] rd);
        bit   hit, err;
        int   waits, exp_waits;
        logic first_resp;
        logic [31:0] exp_rd;
        hit = tr[1] && in_win(a);
        err = hit && bad_size(a, sz);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HADDR = a; HTRANS = tr; HWRITE = wr; HSIZE = sz;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWDATA = wd;
        chk("dbg_sel_data", {31'h0, dbg_sel}, {31'h0, hit});
        waits = 0; first_resp = 1'b0;
        while (!HREADYOUT && waits < 8) begin
            if (waits == 0) first_resp = HRESP;
            waits++;
            @(posedge HCLK); #1;
        end
        exp_waits = err ? 1 : ((hit && !wr) ? WS : 0);
        chk("wait_cycles", waits, exp_waits);
        if (err) chk("err_first_resp", {31'h0, first_resp}, 32'h1);
        chk("resp", {31'h0, HRESP}, {31'h0, err});
        exp_rd = (hit && !err && !wr) ? model[reg_idx(a)] : 32'h0;
        rd = HRDATA;
        chk("rdata", HRDATA, exp_rd);
        @(posedge HCLK); #1;
        if (hit && !err && wr) model_write(a, sz, wd);
        chk("irq", {31'h0, irq}, {31'h0, irq_m});
        chk("dbg_sel_after", {31'h0, dbg_sel}, 32'h0);
    endtask

    task automatic wr_rd_pipe(input logic [31:0] aw, input logic [31:0] wd, input logic [31:0] ar);
        int waits;
        @(posedge HCLK); #1;
        HSEL = 1'b1; HADDR = aw; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'b010;
        @(posedge HCLK); #1;
        HADDR = ar; HTRANS = 2'b10; HWRITE = 1'b0; HWDATA = wd;
        chk("pipe_wr_ready", {31'h0, HREADYOUT}, 32'h1);
        @(posedge HCLK); #1;
        model_write(aw, 3'b010, wd);
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0;
        waits = 0;
        while (!HREADYOUT && waits < 8) begin
            waits++;
            @(posedge HCLK); #1;
        end
        chk("pipe_waits", waits, WS);
        chk("pipe_rdata", HRDATA, model[reg_idx(ar)]);
        @(posedge HCLK); #1;
        chk("pipe_irq", {31'h0, irq}, {31'h0, irq_m});
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [1:0]  tr;
        model_reset();

        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        chk("rst_hresp", {31'h0, HRESP}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_dbg_sel", {31'h0, dbg_sel}, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        xfer(32'h30FF_FFF8, 1'b0, 3'b010, 32'h0, 2'b10, rd);
        chk("rst_readback", rd, 32'h0);

        xfer(32'h30FF_FFF8, 1'b1, 3'b010, 32'hDEAD_BEEF, 2'b10, rd);
        xfer(32'h30FF_FFF8, 1'b0, 3'b010, 32'h0, 2'b10, rd);
        chk("word_rw", rd, 32'hDEAD_BEEF);
        xfer(32'h30FF_FFFC, 1'b0, 3'b010, 32'h0, 2'b10, rd);
        chk("other_reg_zero", rd, 32'h0);

        xfer(32'h30FF_FFF8, 1'b1, 3'b010, 32'h1122_3344, 2'b10, rd);
        xfer(32'h30FF_FFFA, 1'b1, 3'b000, 32'h00AA_0000, 2'b10, rd);
        xfer(32'h30FF_FFF8, 1'b0, 3'b010, 32'h0, 2'b10, rd);
        chk("byte_lane", rd, 32'h11AA_3344);
        xfer(32'h30FF_FFF8, 1'b1, 3'b001, 32'h0000_5566, 2'b10, rd);
        xfer(32'h30FF_FFF8, 1'b0, 3'b010, 32'h0, 2'b10, rd);
        chk("half_lane", rd, 32'h11AA_5566);

        xfer(32'h30FF_FFF9, 1'b1, 3'b010, 32'hFFFF_FFFF, 2'b10, rd);
        xfer(32'h30FF_FFF8, 1'b1, 3'b011, 32'hFFFF_FFFF, 2'b10, rd);
        xfer(32'h30FF_FFF8, 1'b0, 3'b010, 32'h0, 2'b10, rd);
        chk("err_no_update", rd, 32'h11AA_5566);

        xfer(32'h30FF_FFFC, 1'b1, 3'b010, 32'h1, 2'b10, rd);
        chk("doorbell_set", {31'h0, irq}, 32'h1);
        xfer(32'h30FF_FFF0, 1'b1, 3'b010, 32'h0, 2'b10, rd);
        chk("doorbell_other", {31'h0, irq}, 32'h1);
        xfer(32'h30FF_FFFC, 1'b1, 3'b010, 32'h0, 2'b10, rd);
        chk("doorbell_clr", {31'h0, irq}, 32'h0);

        wr_rd_pipe(32'h30FF_FFF4, 32'hCAFE_F00D, 32'h30FF_FFF4);
        wr_rd_pipe(32'h30FF_FFFC, 32'h0000_0100, 32'h30FF_FFF8);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) a = 32'h3000_0000 + $urandom_range(0, 255);
            else a = 32'h30FF_FFF0 + $urandom_range(0, 15);
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            case ($urandom_range(0, 7))
                0: tr = 2'b00;
                1: tr = 2'b01;
                2, 3: tr = 2'b11;
                default: tr = 2'b10;
            endcase
            xfer(a, 1'($urandom_range(0, 1)), sz, $urandom, tr, rd);
        end

        xfer(32'h30FF_FFFC, 1'b1, 3'b010, 32'h8000_0000, 2'b10, rd);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HADDR = 32'h30FF_FFF9; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'b010;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0;
        chk("mid_err1_ready", {31'h0, HREADYOUT}, 32'h0);
        chk("mid_err1_resp", {31'h0, HRESP}, 32'h1);
        #2 HRESETn = 1'b0;
        #1;
        chk("async_rst_ready", {31'h0, HREADYOUT}, 32'h1);
        chk("async_rst_resp", {31'h0, HRESP}, 32'h0);
        chk("async_rst_irq", {31'h0, irq}, 32'h0);
        chk("async_rst_sel", {31'h0, dbg_sel}, 32'h0);
        model_reset();
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int i = 0; i < NR; i++) begin
            xfer(32'h30FF_FFF0 + 32'(4 * i), 1'b0, 3'b010, 32'h0, 2'b10, rd);
            chk("post_rst_val", rd, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
